block_packer: RTL and testbench
===============================

Name: block_packer

Overview:
- Write-side counterpart of the byte-serial block FIFO: accepts one ASCII byte per strobe, assembles 2**ADDR_SPACE_EXP bytes into one parallel block, and presents the block to the SIMON encrypt/decrypt core with a valid/take handshake.
- Sits between the UART/keyboard byte source and the cipher block input.
- Byte 0 lands in the LSBs, the same lane order the read-side FIFO uses to unpack.

Parameters:
- DATA_SIZE, 8, bits per byte lane.
- ADDR_SPACE_EXP, 4, log2 of bytes per block (16 bytes = 128-bit block).
- PAD_BYTE, 8'h20, fill value for unwritten lanes on flush (ASCII space).

Ports:
- clk_100MHz  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- write_to_fifo  in  1  one-cycle strobe: write_data_in is valid.
- write_data_in  in  DATA_SIZE  incoming byte.
- flush  in  1  pad the partial block and complete it.
- read_from_fifo  in  1  consumer takes the presented block.
- read_data_out  out  DATA_SIZE*2**ADDR_SPACE_EXP  assembled block, registered.
- full  out  1  block complete and held for the consumer.
- empty  out  1  no bytes held (count==0 and not full).
- byte_count  out  ADDR_SPACE_EXP+1  bytes currently held, 0..16.
- overflow  out  1  sticky: a byte was dropped.

Behaviour:
- Reset (async, reset_n=0): state FILL, count=0, read_data_out=0, full=0, empty=1, byte_count=0, overflow=0. Reset mid-fill discards the partial block.
- States: FILL and FULL.
- FILL, write_to_fifo=1:
  - Byte is stored in lane [count*8+7 : count*8]; count increments.
  - If count was 15: go to FULL; full=1 on the next cycle, byte_count=16.
- FILL, flush=1 with count>0:
  - Lanes count..15 are set to PAD_BYTE; go to FULL the next cycle.
- FILL, flush=1 with count==0: ignored (no empty blocks).
- FILL, write+flush in the same cycle:
  - The byte is stored at count first, then lanes count+1..15 are padded; go to FULL.
  - If that byte filled lane 15, no padding occurs.
- FILL, read_from_fifo=1: ignored.
- FULL:
  - read_data_out is stable; write and flush alone cannot modify it.
- FULL, read_from_fifo=1 (no write):
  - Next cycle: FILL, count=0, read_data_out cleared to 0, full=0, empty=1.
- FULL, read_from_fifo=1 and write_to_fifo=1 together:
  - The block is released; the new byte is stored at lane 0 of the cleared buffer.
  - Next cycle: FILL, count=1. No byte is lost.
- FULL, write_to_fifo=1 without read: byte dropped, overflow=1 (held until reset).
- FULL, flush: ignored.
- Latency: one cycle from the final write (or flush) to full=1.
- read_data_out is guaranteed meaningful only while full=1.
- Width rules:
  - count is ADDR_SPACE_EXP+1 bits and never exceeds 16.
  - The lane index is count[ADDR_SPACE_EXP-1:0].
- empty and full are never 1 simultaneously.

Decomposition:
- Shared package simon_pkg holds:
  - BLOCK_BYTES = 2**ADDR_SPACE_EXP
  - BLOCK_BITS
  - PAD_BYTE
  - state encoding constants ST_FILL/ST_FULL
- No sub-module needed: the lane write-enable decode is a generate loop inside block_packer. Lane order must match the FIFO unpacker.

Test Plan:
- Reset, then 16 writes of 0x41..0x50 on consecutive cycles:
  - Next cycle full=1, byte_count=16.
  - read_data_out=128'h504F4E4D4C4B4A494847464544434241.
- Writes 0x61,0x62,0x63, then flush:
  - Next cycle full=1.
  - read_data_out=128'h20202020202020202020202020636261.
- Complete block, hold it, strobe write 0x7A with read_from_fifo=0:
  - overflow=1 and the block is unchanged.
  - Then read_from_fifo=1: full=0, empty=1, read_data_out=0; overflow stays 1.
- Complete block, then read_from_fifo=1 and write 0x58 in the same cycle:
  - Next cycle full=0, byte_count=1, read_data_out[7:0]=8'h58, upper bits 0.
- Flush with count=0 → no change, empty=1.
- Write 5 bytes, assert reset_n=0 mid-stream → immediate byte_count=0, read_data_out=0.
  - After release, 16 fresh writes produce a clean block with no leftover bytes.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared constants and state encoding for the SIMON datapath byte packer/unpacker.
package simon_pkg;

   localparam int unsigned DATA_SIZE_DEF      = 8;
   localparam int unsigned ADDR_SPACE_EXP_DEF = 4;
   localparam int unsigned BLOCK_BYTES        = 2 ** ADDR_SPACE_EXP_DEF;
   localparam int unsigned BLOCK_BITS         = DATA_SIZE_DEF * BLOCK_BYTES;
   localparam logic [7:0]  PAD_BYTE           = 8'h20;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_FULL = 1'b1
   } state_e;

endpackage

// File: rtl/block_packer.sv
// Collects one byte per strobe into a parallel cipher block (byte 0 in the LSBs) and holds the
// completed block for the cipher core until it is taken.
module block_packer
   import simon_pkg::*;
#(
   parameter int unsigned          DATA_SIZE      = simon_pkg::DATA_SIZE_DEF,
   parameter int unsigned          ADDR_SPACE_EXP = simon_pkg::ADDR_SPACE_EXP_DEF,
   parameter logic [DATA_SIZE-1:0] PAD_BYTE       = simon_pkg::PAD_BYTE
) (
   input  logic                                      clk_100MHz,
   input  logic                                      reset_n,
   input  logic                                      write_to_fifo,
   input  logic [DATA_SIZE-1:0]                      write_data_in,
   input  logic                                      flush,
   input  logic                                      read_from_fifo,
   output logic [DATA_SIZE*(2**ADDR_SPACE_EXP)-1:0]  read_data_out,
   output logic                                      full,
   output logic                                      empty,
   output logic [ADDR_SPACE_EXP:0]                   byte_count,
   output logic                                      overflow
);

   localparam int unsigned LANES = 2 ** ADDR_SPACE_EXP;
   localparam int unsigned CW    = ADDR_SPACE_EXP + 1;
   localparam int unsigned BITS  = DATA_SIZE * LANES;

   localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
   localparam logic [CW-1:0] COUNT_LAST = CW'(LANES - 1);
   localparam logic [CW-1:0] COUNT_MAX  = CW'(LANES);

   state_e                    r_state;
   logic [CW-1:0]             r_count;
   logic [BITS-1:0]           r_data;
   logic                      r_overflow;

   logic                      w_filling;
   logic                      w_wr_fill;
   logic                      w_complete;
   logic                      w_do_flush;
   logic                      w_release;
   logic [CW-1:0]             w_pad_start;
   logic [ADDR_SPACE_EXP-1:0] w_lane_idx;
   logic [BITS-1:0]           w_data_nxt;

   assign w_filling   = (r_state == ST_FILL);
   assign w_wr_fill   = w_filling & write_to_fifo;
   assign w_complete  = w_wr_fill & (r_count == COUNT_LAST);
   // A same-cycle write counts as content, so write+flush at count 0 still closes a block.
   assign w_do_flush  = w_filling & flush & ((r_count != '0) | write_to_fifo);
   assign w_release   = ~w_filling & read_from_fifo;
   assign w_pad_start = write_to_fifo ? (r_count + COUNT_ONE) : r_count;
   assign w_lane_idx  = r_count[ADDR_SPACE_EXP-1:0];

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      localparam logic [CW-1:0] LANE = CW'(i);
      logic w_wr_lane;
      logic w_pad_lane;

      assign w_wr_lane  = w_wr_fill & (w_lane_idx == LANE[ADDR_SPACE_EXP-1:0]);
      assign w_pad_lane = w_do_flush & (LANE >= w_pad_start);

      // On release the buffer is cleared; a simultaneous write lands in lane 0.
      assign w_data_nxt[i*DATA_SIZE +: DATA_SIZE] =
         w_release  ? (((LANE == '0) && write_to_fifo) ? write_data_in : '0) :
         w_wr_lane  ? write_data_in :
         w_pad_lane ? PAD_BYTE :
                      r_data[i*DATA_SIZE +: DATA_SIZE];
   end

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_FILL;
         r_count    <= '0;
         r_data     <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_data <= w_data_nxt;
         case (r_state)
            ST_FILL: begin
               if (w_complete || w_do_flush) begin
                  r_state <= ST_FULL;
                  r_count <= COUNT_MAX;
               end else if (write_to_fifo) begin
                  r_count <= r_count + COUNT_ONE;
               end
            end
            ST_FULL: begin
               if (read_from_fifo) begin
                  r_state <= ST_FILL;
                  r_count <= write_to_fifo ? COUNT_ONE : '0;
               end else if (write_to_fifo) begin
                  r_overflow <= 1'b1;
               end
            end
            default: r_state <= ST_FILL;
         endcase
      end
   end

   assign read_data_out = r_data;
   assign full          = (r_state == ST_FULL);
   assign empty         = w_filling & (r_count == '0);
   assign byte_count    = r_count;
   assign overflow      = r_overflow;

endmodule

// File: tb/tb_block_packer.sv
// Random and directed stimulus for block_packer, checked against a byte-queue reference model.
module tb_block_packer;
   import simon_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         wr;
   logic [7:0]   wdata;
   logic         fl;
   logic         rd;
   logic [127:0] dout;
   logic         full;
   logic         empty;
   logic [4:0]   cnt;
   logic         ovf;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: bytes held so far, completed block, flags.
   logic [7:0]   m_q[$];
   bit           m_full;
   bit           m_ovf;
   logic [127:0] m_blk;

   always #5 clk = ~clk;

   block_packer dut (
      .clk_100MHz     (clk),
      .reset_n        (rst_n),
      .write_to_fifo  (wr),
      .write_data_in  (wdata),
      .flush          (fl),
      .read_from_fifo (rd),
      .read_data_out  (dout),
      .full           (full),
      .empty          (empty),
      .byte_count     (cnt),
      .overflow       (ovf)
   );

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] pack_q(input bit pad);
      logic [127:0] b;
      b = '0;
      for (int i = 0; i < BLOCK_BYTES; i++) begin
         if (i < m_q.size()) b[i*8 +: 8] = m_q[i];
         else if (pad)       b[i*8 +: 8] = PAD_BYTE;
      end
      return b;
   endfunction

   task automatic check_all(input string tag);
      check_eq({tag, ".full"},  128'(full),  128'(m_full));
      check_eq({tag, ".empty"}, 128'(empty), 128'(!m_full && m_q.size() == 0));
      check_eq({tag, ".count"}, 128'(cnt),   m_full ? 128'd16 : 128'(m_q.size()));
      check_eq({tag, ".ovf"},   128'(ovf),   128'(m_ovf));
      check_eq({tag, ".data"},  dout,        m_full ? m_blk : pack_q(1'b0));
   endtask

   task automatic model_clock(input bit w, input logic [7:0] d, input bit f, input bit r);
      if (!m_full) begin
         if (w) m_q.push_back(d);
         if (m_q.size() == BLOCK_BYTES || (f && m_q.size() > 0)) begin
            m_full = 1'b1;
            m_blk  = pack_q(1'b1);
         end
      end else if (r) begin
         m_full = 1'b0;
         m_q.delete();
         if (w) m_q.push_back(d);
      end else if (w) begin
         m_ovf = 1'b1;
      end
   endtask

   task automatic step(input string tag, input bit w, input logic [7:0] d, input bit f, input bit r);
      wr = w; wdata = d; fl = f; rd = r;
      @(posedge clk);
      model_clock(w, d, f, r);
      #1;
      wr = 1'b0; fl = 1'b0; rd = 1'b0;
      check_all(tag);
   endtask

   task automatic apply_reset(input string tag);
      rst_n = 1'b0;
      #1;
      m_q.delete();
      m_full = 1'b0;
      m_ovf  = 1'b0;
      m_blk  = '0;
      check_all(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic fill_block(input string tag, input logic [7:0] base);
      for (int i = 0; i < BLOCK_BYTES; i++) step(tag, 1'b1, base + 8'(i), 1'b0, 1'b0);
   endtask

   initial begin
      wr = 1'b0; wdata = '0; fl = 1'b0; rd = 1'b0; rst_n = 1'b1;
      #2;
      apply_reset("rst0");

      // Full block of 'A'..'P'.
      fill_block("tp1", 8'h41);
      check_eq("tp1_block", dout, 128'h504F4E4D4C4B4A494847464544434241);
      check_eq("tp1_count", 128'(cnt), 128'd16);
      step("tp1_take", 1'b0, 8'h00, 1'b0, 1'b1);

      // Partial block padded by flush.
      step("tp2", 1'b1, 8'h61, 1'b0, 1'b0);
      step("tp2", 1'b1, 8'h62, 1'b0, 1'b0);
      step("tp2", 1'b1, 8'h63, 1'b0, 1'b0);
      step("tp2_flush", 1'b0, 8'h00, 1'b1, 1'b0);
      check_eq("tp2_full", 128'(full), 128'd1);
      check_eq("tp2_block", dout, 128'h20202020202020202020202020636261);
      step("tp2_take", 1'b0, 8'h00, 1'b0, 1'b1);

      // Overflow while held, then release.
      fill_block("tp3", 8'h41);
      step("tp3_ovf", 1'b1, 8'h7A, 1'b0, 1'b0);
      check_eq("tp3_ovf_flag", 128'(ovf), 128'd1);
      check_eq("tp3_held", dout, 128'h504F4E4D4C4B4A494847464544434241);
      step("tp3_take", 1'b0, 8'h00, 1'b0, 1'b1);
      check_eq("tp3_data0", dout, 128'h0);
      check_eq("tp3_ovf_sticky", 128'(ovf), 128'd1);

      // Take and write in the same cycle.
      fill_block("tp4", 8'h30);
      step("tp4_takewr", 1'b1, 8'h58, 1'b0, 1'b1);
      check_eq("tp4_count", 128'(cnt), 128'd1);
      check_eq("tp4_data", dout, 128'h58);

      // Flush with nothing held is ignored.
      apply_reset("rst1");
      step("tp5_flush0", 1'b0, 8'h00, 1'b1, 1'b0);
      check_eq("tp5_empty", 128'(empty), 128'd1);

      // Write+flush from empty: one byte then padding.
      step("tp5b", 1'b1, 8'h4B, 1'b1, 1'b0);
      check_eq("tp5b_block", dout, 128'h2020202020202020202020202020204B);
      step("tp5b_take", 1'b0, 8'h00, 1'b0, 1'b1);

      // Reset mid-stream discards the partial block.
      for (int i = 0; i < 5; i++) step("tp6", 1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
      #2;
      apply_reset("tp6_rst");
      fill_block("tp6_fresh", 8'h01);
      check_eq("tp6_block", dout, 128'h100F0E0D0C0B0A090807060504030201);
      step("tp6_take", 1'b0, 8'h00, 1'b0, 1'b1);

      // Randomized traffic.
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(299) == 0) begin
            #2;
            apply_reset("rnd_rst");
         end else begin
            step("rnd", $urandom_range(99) < 60, 8'($urandom), $urandom_range(99) < 6,
                 $urandom_range(99) < 25);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
